// File: rtl/fu_dispatch_ctrl_pkg.sv
// Shared types for the function-unit dispatch controller.
//   fu_id_t    : function-unit indices in dispatch order
//   issue_t    : an issued instruction (target FU + word)
//   br_state_t : branch serialisation state
//   NUM_FU, WORD_W : default unit count and instruction word width
package fu_dispatch_ctrl_pkg;

   localparam int unsigned NUM_FU = 5;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      FU_ALU    = 3'd0,
      FU_SLDST  = 3'd1,
      FU_BRANCH = 3'd2,
      FU_MLDST  = 3'd3,
      FU_GEMM   = 3'd4
   } fu_id_t;

   typedef struct packed {
      fu_id_t            fu;
      logic [WORD_W-1:0] word;
   } issue_t;

   typedef enum logic {
      BR_IDLE,
      BR_PENDING
   } br_state_t;

endpackage

// File: rtl/fu_dispatch_ctrl_if.sv
// Dispatch and issue bus between the dispatch stage, the controller and
// the function units.
//   disp_valid/disp_ready/disp_fu_index/disp_word : dispatch handshake
//   issue_valid/issue_word                         : one-hot issue to FUs
//   fu_done                                        : per-FU completion pulse
//   fu_busy                                        : per-FU busy status
// master = dispatch/FU side, slave = controller.
interface fu_dispatch_ctrl_if #(
   parameter int unsigned NUM_FU = 5,
   parameter int unsigned WORD_W = 32
);
   logic              disp_valid;
   logic              disp_ready;
   logic [2:0]        disp_fu_index;
   logic [WORD_W-1:0] disp_word;
   logic [NUM_FU-1:0] issue_valid;
   logic [WORD_W-1:0] issue_word;
   logic [NUM_FU-1:0] fu_done;
   logic [NUM_FU-1:0] fu_busy;

   modport master (
      output disp_valid, disp_fu_index, disp_word, fu_done,
      input  disp_ready, issue_valid, issue_word, fu_busy
   );

   modport slave (
      input  disp_valid, disp_fu_index, disp_word, fu_done,
      output disp_ready, issue_valid, issue_word, fu_busy
   );
endinterface

// File: rtl/fu_dispatch_ctrl_fu_busy_tracker.sv
// Per-FU occupancy tracker: busy bit, watchdog counter and spurious-done
// detection. A pipelined FU never becomes busy and ignores its done.
//   clk, rst     : clock, asynchronous active-high reset
//   issue        : instruction accepted for this FU this cycle
//   done         : FU completion pulse
//   clr          : clear sticky errors
//   busy         : FU occupied
//   spurious     : sticky, done seen while not busy
//   timeout_err  : sticky, busy for TIMEOUT cycles
module fu_busy_tracker #(
   parameter bit          PIPELINED = 1'b0,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic issue,
   input  logic done,
   input  logic clr,
   output logic busy,
   output logic spurious,
   output logic timeout_err
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             issue_np;
   logic             done_np;
   logic             rel;
   logic             expire;

   assign issue_np = issue & ~PIPELINED;
   assign done_np  = done & ~PIPELINED;
   assign rel      = busy & done_np;
   // Counter holds completed busy cycles; the edge that brings it to
   // TIMEOUT (or keeps it saturated there) raises the error.
   assign expire   = busy & ~done_np & (cnt_q >= CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         cnt_q       <= '0;
         spurious    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (issue_np) begin
            busy  <= 1'b1;
            cnt_q <= '0;
         end else if (rel) begin
            busy  <= 1'b0;
            cnt_q <= '0;
         end else if (busy && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
         end
         spurious    <= (done_np & ~busy) | (spurious & ~clr);
         timeout_err <= expire | (timeout_err & ~clr);
      end
   end
endmodule

// File: rtl/fu_dispatch_ctrl.sv
// Issue-stage controller: accepts one dispatched instruction per cycle,
// routes it to its FU one cycle later, blocks on busy FUs and on an
// outstanding branch, and reports protocol errors and hung FUs.
//   clk, rst        : clock, asynchronous active-high reset
//   bus             : dispatch/issue interface (slave side)
//   err_clr         : synchronous clear of all sticky errors
//   branch_pending  : a branch is outstanding
//   err_bad_fu      : sticky, out-of-range FU index dispatched
//   err_spurious    : sticky per FU, done without a busy FU
//   timeout_err     : sticky per FU, watchdog expired
module fu_dispatch_ctrl #(
   parameter int unsigned       NUM_FU       = 5,
   parameter logic [NUM_FU-1:0] FU_PIPELINED = 5'b00001,
   parameter int unsigned       TIMEOUT      = 1024,
   parameter int unsigned       WORD_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   fu_dispatch_ctrl_if.slave bus,
   input  logic              err_clr,
   output logic              branch_pending,
   output logic              err_bad_fu,
   output logic [NUM_FU-1:0] err_spurious,
   output logic [NUM_FU-1:0] timeout_err
);
   import fu_dispatch_ctrl_pkg::*;

   localparam int unsigned BR = int'(FU_BRANCH);
   // The branch unit is always tracked as non-pipelined.
   localparam logic [NUM_FU-1:0] PIPE_EFF = FU_PIPELINED & ~(NUM_FU'(1) << BR);

   logic [NUM_FU-1:0] sel;
   logic              bad_idx;
   logic              disp_ready;
   logic              fire;
   logic [NUM_FU-1:0] fire_sel;
   logic [NUM_FU-1:0] fu_busy;
   logic [NUM_FU-1:0] issue_valid_q;
   logic [WORD_W-1:0] issue_word_q;
   br_state_t         br_state_q;
   br_state_t         br_state_d;

   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         sel[i] = (bus.disp_fu_index == 3'(i));
      end
   end

   // An out-of-range index decodes to no FU and is always accepted.
   assign bad_idx    = ~|sel;
   assign disp_ready = ~rst & ~branch_pending &
                       (bad_idx | (|(sel & (PIPE_EFF | ~fu_busy))));
   assign fire       = bus.disp_valid & disp_ready;
   assign fire_sel   = fire ? sel : '0;

   // Branch serialisation FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_state_q <= BR_IDLE;
      end else begin
         br_state_q <= br_state_d;
      end
   end

   always_comb begin
      br_state_d = br_state_q;
      unique case (br_state_q)
         BR_IDLE:    if (fire_sel[BR])     br_state_d = BR_PENDING;
         BR_PENDING: if (bus.fu_done[BR])  br_state_d = BR_IDLE;
         default:                          br_state_d = BR_IDLE;
      endcase
   end

   always_comb begin
      branch_pending = (br_state_q == BR_PENDING);
   end

   // Issue register and bad-index error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid_q <= '0;
         issue_word_q  <= '0;
         err_bad_fu    <= 1'b0;
      end else begin
         issue_valid_q <= fire_sel;
         if (|fire_sel) begin
            issue_word_q <= bus.disp_word;
         end
         err_bad_fu <= (fire & bad_idx) | (err_bad_fu & ~err_clr);
      end
   end

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      fu_busy_tracker #(
         .PIPELINED (PIPE_EFF[i]),
         .TIMEOUT   (TIMEOUT)
      ) u_trk (
         .clk         (clk),
         .rst         (rst),
         .issue       (fire_sel[i]),
         .done        (bus.fu_done[i]),
         .clr         (err_clr),
         .busy        (fu_busy[i]),
         .spurious    (err_spurious[i]),
         .timeout_err (timeout_err[i])
      );
   end

   assign bus.disp_ready  = disp_ready;
   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_word  = issue_word_q;
   assign bus.fu_busy     = fu_busy;
endmodule

// File: tb/tb_fu_dispatch_ctrl.sv
// Directed bench for fu_dispatch_ctrl with a cycle-level reference model
// (issue ages, pending branch, sticky error sets) and literal spot checks.
module tb_fu_dispatch_ctrl;
   localparam int          TO   = 8;
   localparam logic [4:0]  PIPE = 5'b00001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       err_clr = 1'b0;
   logic       branch_pending;
   logic       err_bad_fu;
   logic [4:0] err_spurious;
   logic [4:0] timeout_err;

   int n_vec = 0;
   int n_err = 0;

   fu_dispatch_ctrl_if #(.NUM_FU(5), .WORD_W(32)) bus ();

   fu_dispatch_ctrl #(
      .NUM_FU       (5),
      .FU_PIPELINED (PIPE),
      .TIMEOUT      (TO),
      .WORD_W       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .err_clr        (err_clr),
      .branch_pending (branch_pending),
      .err_bad_fu     (err_bad_fu),
      .err_spurious   (err_spurious),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_busy [5];
   int         m_start[5];
   bit         m_pend = 0;
   bit         m_bad  = 0;
   bit [4:0]   m_spur = '0;
   bit [4:0]   m_to   = '0;
   bit [4:0]   m_iv   = '0;
   logic [31:0] m_iw  = '0;
   int         cyc    = 0;
   bit         f_m;
   int         idx_m;
   bit [4:0]   sp_set, to_set;
   bit         bad_set;

   function automatic bit is_pipe(int i);
      return PIPE[i] && (i != 2);
   endfunction

   function automatic bit exp_ready();
      int i;
      i = int'(bus.disp_fu_index);
      if (rst || m_pend) return 1'b0;
      if (i >= 5) return 1'b1;
      return is_pipe(i) || !m_busy[i];
   endfunction

   function automatic logic [4:0] busy_vec();
      logic [4:0] v;
      for (int i = 0; i < 5; i++) v[i] = m_busy[i];
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 5; i++) begin m_busy[i] = 0; m_start[i] = 0; end
         m_pend = 0; m_bad = 0; m_spur = '0; m_to = '0; m_iv = '0; m_iw = '0;
      end else begin
         cyc++;
         f_m = bus.disp_valid && exp_ready();
         idx_m = int'(bus.disp_fu_index);
         sp_set = '0; to_set = '0; bad_set = 0;
         for (int i = 0; i < 5; i++) begin
            if (!is_pipe(i)) begin
               if (bus.fu_done[i] && !m_busy[i]) sp_set[i] = 1;
               else if (bus.fu_done[i]) begin
                  m_busy[i] = 0;
                  if (i == 2) m_pend = 0;
               end else if (m_busy[i] && (cyc - m_start[i]) >= TO) to_set[i] = 1;
            end
         end
         m_iv = '0;
         if (f_m) begin
            if (idx_m < 5) begin
               m_iv[idx_m] = 1;
               m_iw = bus.disp_word;
               if (!is_pipe(idx_m)) begin m_busy[idx_m] = 1; m_start[idx_m] = cyc; end
               if (idx_m == 2) m_pend = 1;
            end else bad_set = 1;
         end
         m_spur = sp_set | (err_clr ? 5'b0 : m_spur);
         m_to   = to_set | (err_clr ? 5'b0 : m_to);
         m_bad  = bad_set | (err_clr ? 1'b0 : m_bad);
      end
   end

   always @(negedge clk) begin
      chk("disp_ready",     32'(bus.disp_ready),  32'(exp_ready()));
      chk("issue_valid",    32'(bus.issue_valid), 32'(m_iv));
      chk("issue_word",     bus.issue_word,       m_iw);
      chk("fu_busy",        32'(bus.fu_busy),     32'(busy_vec()));
      chk("branch_pending", 32'(branch_pending),  32'(m_pend));
      chk("err_bad_fu",     32'(err_bad_fu),      32'(m_bad));
      chk("err_spurious",   32'(err_spurious),    32'(m_spur));
      chk("timeout_err",    32'(timeout_err),     32'(m_to));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input bit v, input logic [2:0] idx, input logic [31:0] w);
      bus.disp_valid    = v;
      bus.disp_fu_index = idx;
      bus.disp_word     = w;
   endtask

   initial begin
      disp(0, 3'd0, 32'h0);
      bus.fu_done = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_ready",  32'(bus.disp_ready),  32'd1);
      chk("rst_iv",     32'(bus.issue_valid), 32'd0);
      chk("rst_busy",   32'(bus.fu_busy),     32'd0);
      chk("rst_errs",   32'({err_bad_fu, err_spurious, timeout_err}), 32'd0);

      // Back-to-back ALU
      for (int k = 0; k < 4; k++) begin
         disp(1, 3'd0, 32'hA000_0000 + 32'(k));
         #1 chk("alu_ready", 32'(bus.disp_ready), 32'd1);
         tick();
         chk("alu_iv", 32'(bus.issue_valid), 32'h01);
         chk("alu_iw", bus.issue_word, 32'hA000_0000 + 32'(k));
      end
      disp(0, 3'd0, 32'h0);
      tick();
      chk("alu_iv_off", 32'(bus.issue_valid), 32'd0);

      // GEMM structural hazard
      disp(1, 3'd4, 32'hB000_000A);
      tick();
      chk("gemm_iv1",   32'(bus.issue_valid), 32'h10);
      chk("gemm_busy1", 32'(bus.fu_busy),     32'h10);
      disp(1, 3'd4, 32'hB000_000B);
      #1 chk("gemm_block", 32'(bus.disp_ready), 32'd0);
      tick(); tick();
      bus.fu_done = 5'b10000;
      #1 chk("gemm_nobypass", 32'(bus.disp_ready), 32'd0);
      tick();
      bus.fu_done = '0;
      #1 chk("gemm_accept", 32'(bus.disp_ready), 32'd1);
      tick();
      chk("gemm_iv2", 32'(bus.issue_valid), 32'h10);
      chk("gemm_iw2", bus.issue_word, 32'hB000_000B);
      disp(0, 3'd0, 32'h0);
      tick();
      bus.fu_done = 5'b10000;
      tick();
      bus.fu_done = '0;

      // Branch stall
      disp(1, 3'd2, 32'hC000_0002);
      tick();
      chk("br_iv",   32'(bus.issue_valid), 32'h04);
      chk("br_pend", 32'(branch_pending),  32'd1);
      disp(1, 3'd0, 32'hD000_0000);
      #1 chk("br_stall", 32'(bus.disp_ready), 32'd0);
      tick(); tick();
      bus.fu_done = 5'b00100;
      #1 chk("br_stall_n", 32'(bus.disp_ready), 32'd0);
      tick();
      bus.fu_done = '0;
      #1 chk("br_accept", 32'(bus.disp_ready), 32'd1);
      chk("br_clear", 32'(branch_pending), 32'd0);
      tick();
      chk("br_alu_iv", 32'(bus.issue_valid), 32'h01);
      chk("br_alu_iw", bus.issue_word, 32'hD000_0000);
      disp(0, 3'd0, 32'h0);
      tick();

      // Errors
      disp(1, 3'd6, 32'hE000_0006);
      #1 chk("bad_ready", 32'(bus.disp_ready), 32'd1);
      tick();
      disp(0, 3'd0, 32'h0);
      chk("bad_iv",  32'(bus.issue_valid), 32'd0);
      chk("bad_err", 32'(err_bad_fu),      32'd1);
      chk("bad_iw",  bus.issue_word, 32'hD000_0000);
      bus.fu_done = 5'b01001;
      tick();
      bus.fu_done = '0;
      chk("spur", 32'(err_spurious), 32'h08);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_bad",  32'(err_bad_fu),   32'd0);
      chk("clr_spur", 32'(err_spurious), 32'd0);
      err_clr = 1'b1;
      bus.fu_done = 5'b01000;
      tick();
      err_clr = 1'b0;
      bus.fu_done = '0;
      chk("clr_setwins", 32'(err_spurious), 32'h08);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // Watchdog
      disp(1, 3'd3, 32'hF000_0003);
      tick();
      disp(0, 3'd0, 32'h0);
      repeat (7) tick();
      chk("wd_before", 32'(timeout_err), 32'd0);
      tick();
      chk("wd_hit",  32'(timeout_err), 32'h08);
      chk("wd_busy", 32'(bus.fu_busy), 32'h08);
      tick(); tick();
      bus.fu_done = 5'b01000;
      tick();
      bus.fu_done = '0;
      chk("wd_rel",    32'(bus.fu_busy), 32'd0);
      chk("wd_sticky", 32'(timeout_err), 32'h08);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("wd_clr", 32'(timeout_err), 32'd0);

      // Simultaneous fire and done to different FUs; multiple dones
      disp(1, 3'd3, 32'h1111_0003);
      tick();
      disp(1, 3'd4, 32'h1111_0004);
      bus.fu_done = 5'b01000;
      #1 chk("sim_ready", 32'(bus.disp_ready), 32'd1);
      tick();
      bus.fu_done = '0;
      disp(1, 3'd1, 32'h1111_0001);
      chk("sim_busy", 32'(bus.fu_busy), 32'h10);
      tick();
      disp(0, 3'd0, 32'h0);
      chk("sim_busy2", 32'(bus.fu_busy), 32'h12);
      bus.fu_done = 5'b10010;
      tick();
      bus.fu_done = '0;
      chk("multi_done", 32'(bus.fu_busy),    32'd0);
      chk("multi_spur", 32'(err_spurious),   32'd0);

      // Reset mid-GEMM, with a sticky error outstanding
      disp(1, 3'd7, 32'h0);
      tick();
      disp(1, 3'd4, 32'h2222_0004);
      tick();
      disp(0, 3'd0, 32'h0);
      chk("pre_rst_busy", 32'(bus.fu_busy), 32'h10);
      chk("pre_rst_bad",  32'(err_bad_fu),  32'd1);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("arst_busy",  32'(bus.fu_busy),     32'd0);
      chk("arst_iv",    32'(bus.issue_valid), 32'd0);
      chk("arst_iw",    bus.issue_word,       32'd0);
      chk("arst_ready", 32'(bus.disp_ready),  32'd0);
      chk("arst_errs",  32'({err_bad_fu, err_spurious, timeout_err}), 32'd0);
      tick();
      rst = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end
endmodule

// File: doc/fu_dispatch_ctrl.md
Name: fu_dispatch_ctrl

Overview:
- Issue-stage controller between the dispatch stage and the tensor core's function units.
- FUs in index order: scalar ALU (0), scalar LD_ST (1), scalar BRANCH (2), matrix LD_ST (3), GEMM (4).
- Accepts one dispatched instruction per cycle and routes it to its target FU.
- Tracks structural hazards (busy FUs), serialises on outstanding branches, and flags protocol errors and hung FUs.

Parameters:
- NUM_FU, 5, number of function units; index = dispatch fu_index.
- FU_PIPELINED, 5'b00001, bit i set = FU i accepts every cycle and is never marked busy.
- TIMEOUT, 1024, cycles an FU may stay busy before its timeout error sets.
- WORD_W, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  1  dispatch presents an instruction.
- disp_ready  out  1  controller accepts it this cycle.
- disp_fu_index  in  3  target FU index.
- disp_word  in  WORD_W  instruction word.
- issue_valid  out  NUM_FU  one-hot issue strobe to the FUs.
- issue_word  out  WORD_W  instruction word for the issued FU.
- fu_done  in  NUM_FU  per-FU completion pulse.
- fu_busy  out  NUM_FU  busy bits.
- branch_pending  out  1  a branch is outstanding.
- err_bad_fu  out  1  sticky: fu_index >= NUM_FU was dispatched.
- err_spurious  out  NUM_FU  sticky: fu_done arrived for a non-busy, non-pipelined FU.
- timeout_err  out  NUM_FU  sticky per-FU timeout.
- err_clr  in  1  synchronous clear of all sticky errors.

Behaviour:
- Reset (asynchronous, active-high): every output register, busy bit, counter and error clears to 0. issue_word resets to 0. Any in-flight issue is dropped; FUs are reset by the same rst.
- disp_ready is combinational: !rst & !branch_pending & (disp_fu_index >= NUM_FU | FU_PIPELINED[idx] | !fu_busy[idx]).
- fire = disp_valid & disp_ready. disp_ready does not depend on disp_valid.
- Latency: on fire with a valid index, issue_valid[idx]=1 and issue_word=disp_word in the next cycle, for exactly one cycle. issue_valid is 0 otherwise; issue_word holds its last value.
- Busy tracking:
  - On fire to a non-pipelined FU, fu_busy[idx] sets at the same edge issue_valid is registered.
  - fu_busy[i] clears at the edge after fu_done[i] is sampled.
  - No done->issue bypass: a done in cycle N allows issue to that FU no earlier than cycle N+1.
- Branch serialisation:
  - On fire to index 2, branch_pending sets; it clears with fu_done[2].
  - While pending, disp_ready=0 for all indices.
  - The BRANCH FU is always treated as non-pipelined, regardless of FU_PIPELINED.
- Bad index: fire is accepted (disp_ready=1), the instruction is dropped, no issue occurs, and err_bad_fu sets.
- Spurious done: fu_done[i] while !fu_busy[i] on a non-pipelined FU sets err_spurious[i] with no other effect. fu_done on a pipelined FU is ignored.
- Watchdog, per non-pipelined FU:
  - Counter is 0 while idle and increments each cycle busy.
  - When it reaches TIMEOUT, timeout_err[i] sets and the counter saturates; busy remains set.
  - Counter clears when busy clears.
- err_clr: clears all sticky errors at the next edge. If an error condition occurs in the same cycle, the set wins.
- Simultaneous events:
  - fire and fu_done to different FUs in the same cycle are both honoured.
  - Multiple fu_done bits in one cycle are all honoured.

Decomposition:
- types_pkg additions:
  - fu_id_t enum (FU_ALU=0, FU_SLDST=1, FU_BRANCH=2, FU_MLDST=3, FU_GEMM=4). Distinct enumerator names; no duplicate LD_ST labels.
  - NUM_FU constant.
  - issue_t struct {fu_id_t fu; logic [WORD_W-1:0] word}.
- Sub-module fu_busy_tracker, instantiated once per FU: busy bit, watchdog counter, spurious detect.

Test Plan:
- Reset mid-GEMM: issue to FU 4, assert rst 3 cycles later -> fu_busy=0, issue_valid=0, all errors 0 immediately (asynchronous).
- Back-to-back ALU: disp_valid=1, idx 0 for 4 cycles -> disp_ready=1 throughout; issue_valid=5'b00001 for 4 consecutive cycles, each one cycle after its fire.
- GEMM hazard: issue idx 4, hold a second idx-4 dispatch -> disp_ready=0 until the cycle after fu_done[4]; second issue_valid=5'b10000 appears 1 cycle after that acceptance.
- Branch stall: issue idx 2, then offer idx 0 -> disp_ready=0 while branch_pending; fu_done[2] in cycle N -> ALU accepted in N+1, issued in N+2.
- Errors: dispatch idx 6 -> accepted, no issue_valid, err_bad_fu=1. fu_done[3] while idle -> err_spurious=5'b01000. err_clr -> both 0.
- Watchdog with TIMEOUT=8: issue idx 3, withhold done -> timeout_err[3]=1 at cycle 8 of busy; fu_busy[3] remains 1; fu_done[3] clears busy, error stays sticky.
